// File: rtl/fragment_output_queue_pkg.sv
// Shared raster fragment definitions: field widths and the packed {x,y,z,attr} layout
// used by the interpolator, depth test and output queue.
package fragment_output_queue_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int DEPTH_W_DEF = 32;
  localparam int ATTR_W_DEF  = 24;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [DEPTH_W_DEF-1:0] z;
    logic [ATTR_W_DEF-1:0]  attr;
  } fragment_t;

  localparam int FRAG_W_DEF = $bits(fragment_t);

  // Packed width of a fragment with {x,y,z,attr} ordered MSB to LSB.
  function automatic int frag_width(input int coord_w, input int depth_w, input int attr_w);
    return 2 * coord_w + depth_w + attr_w;
  endfunction

endpackage

// File: rtl/fragment_output_queue_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fragment_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 76
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fragment_output_queue.sv
// Fragment output queue: circular FIFO storage feeding a single output register with
// valid/ready handshake, flush, almost-full flag and a saturating drop counter.
module fragment_output_queue
  import fragment_output_queue_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int DEPTH_W    = DEPTH_W_DEF,
  parameter int ATTR_W     = ATTR_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int DROP_W     = 16,
  localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [COORD_W-1:0] fragment_x_in,
  input  logic [COORD_W-1:0] fragment_y_in,
  input  logic [DEPTH_W-1:0] fragment_z_in,
  input  logic [ATTR_W-1:0]  fragment_attr_in,
  output logic               ready_out,
  input  logic               flush,
  input  logic               ready_in,
  output logic               valid_out_buffer,
  output logic [COORD_W-1:0] fragment_x_out,
  output logic [COORD_W-1:0] fragment_y_out,
  output logic [DEPTH_W-1:0] fragment_z_out,
  output logic [ATTR_W-1:0]  fragment_attr_out,
  output logic [ADDR_W:0]    level,
  output logic               almost_full,
  output logic [DROP_W-1:0]  drop_count
);

  localparam int FRAG_W = frag_width(COORD_W, DEPTH_W, ATTR_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_q, level_next;
  logic              accept, load, drop;
  logic [FRAG_W-1:0] wr_frag_p0, head_p0, frag_p1;
  logic              vld_p1;

  assign ready_out = (level_q < DEPTH_L) && !flush;
  assign accept    = valid_in && ready_out;
  assign drop      = valid_in && !ready_out;
  // Output register refills whenever it is empty or being consumed this cycle.
  assign load      = (level_q != '0) && (!vld_p1 || ready_in) && !flush;

  always_comb begin
    level_next = level_q;
    case ({accept, load})
      2'b10:   level_next = level_q + ONE_L;
      2'b01:   level_next = level_q - ONE_L;
      default: level_next = level_q;
    endcase
  end

  // Stage p0: storage write and head read
  assign wr_frag_p0 = {fragment_x_in, fragment_y_in, fragment_z_in, fragment_attr_in};

  fragment_fifo_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (FRAG_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_frag_p0),
    .rd_addr (rd_ptr),
    .rd_data (head_p0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      vld_p1  <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (load)   rd_ptr <= rd_ptr + ADDR_W'(1);
      level_q <= level_next;
      if (load)          vld_p1 <= 1'b1;
      else if (ready_in) vld_p1 <= 1'b0;
    end
  end

  // Stage p1: output register, data held across stalls and flushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      frag_p1 <= '0;
    else if (load) frag_p1 <= head_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      drop_count <= '0;
    else if (drop) drop_count <= sat_inc(drop_count);
  end

  assign valid_out_buffer = vld_p1;
  assign {fragment_x_out, fragment_y_out, fragment_z_out, fragment_attr_out} = frag_p1;
  assign level       = level_q;
  assign almost_full = (level_q >= AF_L);

endmodule

// File: tb/tb_fragment_output_queue.sv
// Directed bench for fragment_output_queue at FIFO_DEPTH=4, AF_THRESH=2, DROP_W=4.
module tb_fragment_output_queue;

  localparam int CW = 10, DW = 32, AW = 24, FD = 4, AFT = 2, DRW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [CW-1:0] fragment_x_in, fragment_y_in;
  logic [DW-1:0] fragment_z_in;
  logic [AW-1:0] fragment_attr_in;
  logic          ready_out;
  logic          flush;
  logic          ready_in;
  logic          valid_out_buffer;
  logic [CW-1:0] fragment_x_out, fragment_y_out;
  logic [DW-1:0] fragment_z_out;
  logic [AW-1:0] fragment_attr_out;
  logic [2:0]    level;
  logic          almost_full;
  logic [DRW-1:0] drop_count;

  always #5 clk = ~clk;

  fragment_output_queue #(
    .COORD_W (CW), .DEPTH_W (DW), .ATTR_W (AW),
    .FIFO_DEPTH (FD), .AF_THRESH (AFT), .DROP_W (DRW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .fragment_x_in     (fragment_x_in),
    .fragment_y_in     (fragment_y_in),
    .fragment_z_in     (fragment_z_in),
    .fragment_attr_in  (fragment_attr_in),
    .ready_out         (ready_out),
    .flush             (flush),
    .ready_in          (ready_in),
    .valid_out_buffer  (valid_out_buffer),
    .fragment_x_out    (fragment_x_out),
    .fragment_y_out    (fragment_y_out),
    .fragment_z_out    (fragment_z_out),
    .fragment_attr_out (fragment_attr_out),
    .level             (level),
    .almost_full       (almost_full),
    .drop_count        (drop_count)
  );

  typedef struct {
    int vi, x, rdy, fl;
    int e_vld, e_x, e_lvl, e_rdyo, e_af, e_drop;
  } vec_t;

  vec_t tbl[27];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int vi, input int x, input int rdy, input int fl);
    valid_in         = (vi != 0);
    fragment_x_in    = CW'(x);
    fragment_y_in    = CW'(x + 1);
    fragment_z_in    = DW'(x * 16);
    fragment_attr_in = AW'(x * 3);
    ready_in         = (rdy != 0);
    flush            = (fl != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          vi  x  rdy fl | vld ex lvl rdyo af drop
    tbl[0]  = '{1,  1, 1,  0,   0,  0, 1,  1,   0, 0};
    tbl[1]  = '{0,  0, 1,  0,   1,  1, 0,  1,   0, 0};
    tbl[2]  = '{0,  0, 1,  0,   0,  1, 0,  1,   0, 0};
    tbl[3]  = '{1,  2, 0,  0,   0,  1, 1,  1,   0, 0};
    tbl[4]  = '{1,  3, 0,  0,   1,  2, 1,  1,   0, 0};
    tbl[5]  = '{1,  4, 0,  0,   1,  2, 2,  1,   1, 0};
    tbl[6]  = '{1,  5, 0,  0,   1,  2, 3,  1,   1, 0};
    tbl[7]  = '{1,  6, 0,  0,   1,  2, 4,  0,   1, 0};
    tbl[8]  = '{1,  7, 0,  0,   1,  2, 4,  0,   1, 1};
    tbl[9]  = '{0,  0, 0,  0,   1,  2, 4,  0,   1, 1};
    tbl[10] = '{0,  0, 0,  0,   1,  2, 4,  0,   1, 1};
    tbl[11] = '{0,  0, 0,  0,   1,  2, 4,  0,   1, 1};
    tbl[12] = '{0,  0, 0,  0,   1,  2, 4,  0,   1, 1};
    tbl[13] = '{0,  0, 1,  0,   1,  3, 3,  1,   1, 1};
    tbl[14] = '{0,  0, 1,  0,   1,  4, 2,  1,   1, 1};
    tbl[15] = '{0,  0, 1,  0,   1,  5, 1,  1,   0, 1};
    tbl[16] = '{0,  0, 1,  0,   1,  6, 0,  1,   0, 1};
    tbl[17] = '{0,  0, 1,  0,   0,  6, 0,  1,   0, 1};
    tbl[18] = '{1,  8, 0,  0,   0,  6, 1,  1,   0, 1};
    tbl[19] = '{1,  9, 0,  0,   1,  8, 1,  1,   0, 1};
    tbl[20] = '{1, 10, 0,  0,   1,  8, 2,  1,   1, 1};
    tbl[21] = '{1, 11, 0,  0,   1,  8, 3,  1,   1, 1};
    tbl[22] = '{1, 12, 0,  0,   1,  8, 4,  0,   1, 1};
    tbl[23] = '{1, 13, 1,  0,   1,  9, 3,  1,   1, 2};
    tbl[24] = '{1, 14, 1,  0,   1, 10, 3,  1,   1, 2};
    tbl[25] = '{1, 15, 0,  1,   0, 10, 0,  0,   0, 3};
    tbl[26] = '{0,  0, 0,  0,   0, 10, 0,  1,   0, 3};

    rst = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_vld",   64'(valid_out_buffer), 64'd0);
    chk("reset_level", 64'(level),            64'd0);
    chk("reset_drop",  64'(drop_count),       64'd0);
    chk("reset_rdyo",  64'(ready_out),        64'd1);
    chk("reset_x",     64'(fragment_x_out),   64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].vi, tbl[i].x, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("v%0d_vld", i),  64'(valid_out_buffer), 64'(tbl[i].e_vld));
      chk($sformatf("v%0d_x", i),    64'(fragment_x_out),   64'(tbl[i].e_x));
      chk($sformatf("v%0d_lvl", i),  64'(level),            64'(tbl[i].e_lvl));
      chk($sformatf("v%0d_rdyo", i), 64'(ready_out),        64'(tbl[i].e_rdyo));
      chk($sformatf("v%0d_af", i),   64'(almost_full),      64'(tbl[i].e_af));
      chk($sformatf("v%0d_drop", i), 64'(drop_count),       64'(tbl[i].e_drop));
    end

    // single fragment with explicit field values, two-edge latency
    valid_in = 1'b1; ready_in = 1'b1; flush = 1'b0;
    fragment_x_in = 10'd5; fragment_y_in = 10'd7;
    fragment_z_in = 32'h100; fragment_attr_in = 24'hFF0000;
    step();
    chk("single_vld_edge1", 64'(valid_out_buffer), 64'd0);
    valid_in = 1'b0;
    step();
    chk("single_vld_edge2", 64'(valid_out_buffer),  64'd1);
    chk("single_x",         64'(fragment_x_out),    64'd5);
    chk("single_y",         64'(fragment_y_out),    64'd7);
    chk("single_z",         64'(fragment_z_out),    64'h100);
    chk("single_attr",      64'(fragment_attr_out), 64'hFF0000);
    step();
    chk("single_vld_after", 64'(valid_out_buffer), 64'd0);

    // continuous streaming, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      drive(1, 100 + i, 1, 0);
      step();
      chk($sformatf("stream%0d_lvl", i), 64'(level), 64'd1);
      chk($sformatf("stream%0d_vld", i), 64'(valid_out_buffer), (i >= 1) ? 64'd1 : 64'd0);
      if (i >= 1) chk($sformatf("stream%0d_x", i), 64'(fragment_x_out), 64'(100 + i - 1));
    end
    drive(0, 0, 1, 0);
    step();
    chk("stream_tail_x",   64'(fragment_x_out), 64'd119);
    chk("stream_tail_lvl", 64'(level),          64'd0);
    step();
    chk("stream_done_vld", 64'(valid_out_buffer), 64'd0);
    chk("stream_drop",     64'(drop_count),       64'd3);

    // drop counter saturation while flush rejects every fragment
    for (int i = 0; i < 20; i++) begin
      drive(1, 200 + i, 0, 1);
      step();
      if (i == 10) chk("drop_mid", 64'(drop_count), 64'd14);
    end
    chk("drop_sat",     64'(drop_count), 64'd15);
    chk("drop_sat_lvl", 64'(level),      64'd0);
    drive(0, 0, 0, 0);
    step();

    // asynchronous reset mid-stream
    drive(1, 50, 0, 0);
    step();
    drive(1, 51, 0, 0);
    step();
    chk("prerst_vld", 64'(valid_out_buffer), 64'd1);
    chk("prerst_x",   64'(fragment_x_out),   64'd50);
    drive(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld",   64'(valid_out_buffer),  64'd0);
    chk("arst_x",     64'(fragment_x_out),    64'd0);
    chk("arst_y",     64'(fragment_y_out),    64'd0);
    chk("arst_z",     64'(fragment_z_out),    64'd0);
    chk("arst_attr",  64'(fragment_attr_out), 64'd0);
    chk("arst_level", 64'(level),             64'd0);
    chk("arst_drop",  64'(drop_count),        64'd0);
    chk("arst_af",    64'(almost_full),       64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 60, 1, 0);
    step();
    chk("postrst_vld1", 64'(valid_out_buffer), 64'd0);
    chk("postrst_lvl",  64'(level),            64'd1);
    drive(0, 0, 1, 0);
    step();
    chk("postrst_vld2", 64'(valid_out_buffer), 64'd1);
    chk("postrst_x",    64'(fragment_x_out),   64'd60);
    chk("postrst_drop", 64'(drop_count),       64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fragment_output_queue.md
FRAGMENT_OUTPUT_QUEUE -- requirements
Module: fragment_output_queue

Interface
REQ-001 SHALL have parameter COORD_W, default 10, width of fragment x and y.
REQ-002 SHALL have parameter DEPTH_W, default 32, width of fragment z.
REQ-003 SHALL have parameter ATTR_W, default 24, width of packed fragment attribute (colour) field.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, storage entries, power of two, minimum 2.
REQ-005 SHALL have parameter AF_THRESH, default FIFO_DEPTH-2, almost-full level.
REQ-006 SHALL have parameter DROP_W, default 16, width of drop counter.
REQ-007 SHALL derive localparam ADDR_W = $clog2(FIFO_DEPTH).
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 valid_in  input  1  upstream fragment valid.
REQ-011 fragment_x_in, fragment_y_in  input  COORD_W  fragment coordinates.
REQ-012 fragment_z_in  input  DEPTH_W  fragment depth.
REQ-013 fragment_attr_in  input  ATTR_W  fragment attribute.
REQ-014 ready_out  output  1  queue can accept a fragment this cycle.
REQ-015 flush  input  1  synchronous discard of all queued and presented fragments.
REQ-016 ready_in  input  1  downstream accepts the presented fragment.
REQ-017 valid_out_buffer  output  1  output fragment valid.
REQ-018 fragment_x_out, fragment_y_out, fragment_z_out, fragment_attr_out  output  COORD_W/COORD_W/DEPTH_W/ATTR_W  presented fragment.
REQ-019 level  output  ADDR_W+1  entries in storage, excluding the output register.
REQ-020 almost_full  output  1  level >= AF_THRESH.
REQ-021 drop_count  output  DROP_W  saturating count of rejected fragments.

Function
REQ-022 Storage: circular FIFO of FIFO_DEPTH entries of {x,y,z,attr}, write/read pointers wrap from FIFO_DEPTH-1 to 0.
REQ-023 ready_out = (level < FIFO_DEPTH) && !flush, combinational; accept = valid_in && ready_out.
REQ-024 Output register: holds one fragment; valid_out_buffer and data SHALL remain stable while valid_out_buffer && !ready_in.
REQ-025 Output register loads head of storage when level > 0 and (register empty or ready_in); otherwise, if ready_in, valid_out_buffer falls to 0.
REQ-026 Latency: fragment accepted at edge N into empty queue with empty register SHALL appear with valid_out_buffer=1 after edge N+1.
REQ-027 Simultaneous accept and output load: level unchanged, both pointers advance.
REQ-028 Order SHALL be strict FIFO; no fragment duplicated or lost except by flush.
REQ-029 Full: accept blocked, no overwrite; load from full storage in the same cycle frees an entry only from the next cycle.
REQ-030 Drop: each cycle with valid_in=1 and ready_out=0 SHALL increment drop_count, saturating at all-ones.
REQ-031 Flush asserted at an edge: pointers, level, valid_out_buffer cleared; data outputs hold; drop_count unchanged; valid_in that cycle counts as a drop.
REQ-032 almost_full SHALL be registered-consistent with level (derived from same-cycle level).

Reset
REQ-033 rst=0 SHALL immediately clear pointers, level, valid_out_buffer, all data outputs, drop_count to 0; storage contents need not be cleared.
REQ-034 Reset mid-operation SHALL discard all fragments; first accept after release behaves per REQ-026.

Structure
REQ-035 Fragment field widths and packed-fragment layout {x,y,z,attr} SHALL live in the shared raster package for reuse by interpolator and depth test.
REQ-036 One sub-module SHALL be used: fragment_fifo_mem, a simple dual-port register array (write port, async read port).

Verification (FIFO_DEPTH=4, AF_THRESH=2, DROP_W=4)
REQ-037 Single fragment (x=5,y=7,z=0x100,attr=0xFF0000), ready_in=1 -> valid_out_buffer after 2 edges with those values, then 0.
REQ-038 Push 6 fragments, ready_in=0 -> 4 in storage + 1 in output register, ready_out=0 when level=4, almost_full at level 2, drop_count=1 from 6th.
REQ-039 Stall: ready_in=0 for 5 cycles with valid output -> outputs constant; release -> fragments drained in order 1..5.
REQ-040 Continuous valid_in and ready_in for 20 cycles -> 1 fragment/cycle, level constant, pointers wrap, order preserved.
REQ-041 flush with level=3 and valid output -> next cycle valid_out_buffer=0, level=0; rst=0 mid-stream -> all outputs 0 asynchronously.
REQ-042 20 rejected cycles -> drop_count saturates at 15.
